cpu_bus_bridge: RTL and testbench

- Parametrised 80286 local-bus bridge; successor to the hand-coded status decode, address decode and toggle-handshake logic in the top level.
- Samples 286 status and address on a CPU-phase strobe, then decodes against NCH programmable channel windows (memory or I/O).
- Issues toggle read/write requests per channel and holds READY until each channel acknowledges.
- Muxes return data, answers INTA with the PIC vector, and terminates unmapped or hung cycles itself (default data, timeout).

---
 rtl/cpu_bus_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_cpu_bus_bridge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_bridge.sv
// 80286 local-bus bridge: latches status/address on the CPU-phase strobe, decodes
// against programmable channel windows and runs toggle request/ack handshakes.
module cpu_bus_bridge #(
  parameter int              NCH     = 8,
  parameter int              AW      = 24,
  parameter int              DW      = 16,
  parameter logic [NCH*AW-1:0] CH_BASE = '0,
  parameter logic [NCH*AW-1:0] CH_MASK = '0,
  parameter logic [NCH-1:0]  CH_IO   = '0,
  parameter int              TIMEOUT = 255,
  parameter int              TW      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [AW-1:0]     cpu_a,
  input  logic [DW-1:0]     cpu_d_in,
  input  logic              cpu_bhe_n,
  input  logic              cpu_s0_n,
  input  logic              cpu_s1_n,
  input  logic              cpu_mio,
  input  logic              cpu_inta_n,
  output logic              cpu_ready,
  output logic [DW-1:0]     cpu_d_out,
  output logic              cpu_d_oe,
  output logic [AW-1:0]     c_a,
  output logic [DW-1:0]     c_d,
  output logic              c_bhe_n,
  output logic [NCH-1:0]    rd_req,
  output logic [NCH-1:0]    wr_req,
  input  logic [NCH-1:0]    rd_ack,
  input  logic [NCH-1:0]    wr_ack,
  input  logic [NCH*DW-1:0] ch_dout,
  input  logic [7:0]        irq_vector,
  output logic              timeout_err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     r_state;
  logic [AW-1:0]  r_c_a;
  logic [DW-1:0]  r_c_d;
  logic           r_c_bhe_n;
  logic           r_ready;
  logic           r_oe;
  logic [DW-1:0]  r_dout;
  logic [NCH-1:0] r_rd_req;
  logic [NCH-1:0] r_wr_req;
  logic           r_is_rd;
  logic           r_is_wr;
  logic           r_is_inta;
  logic [CW-1:0]  r_ch;
  logic           r_hit;
  logic [TW-1:0]  r_cnt;
  logic           r_timeout_err;

  logic [3:0]     w_cmd;
  logic           w_mrd, w_mwr, w_iord, w_iowr, w_inta;
  logic           w_start;
  logic           w_io;
  logic [AW-1:0]  w_space_mask;
  logic           w_hit;
  logic [CW-1:0]  w_ch;
  logic           w_ack_done;
  logic [DW-1:0]  w_ch_data;

  assign w_cmd   = {cpu_inta_n, cpu_mio, cpu_s1_n, cpu_s0_n};
  assign w_mrd   = (w_cmd[2:0] == 3'b101);
  assign w_mwr   = (w_cmd[2:0] == 3'b110);
  assign w_iord  = (w_cmd[2:0] == 3'b001);
  assign w_iowr  = (w_cmd[2:0] == 3'b010);
  assign w_inta  = (w_cmd == 4'b0000);
  // Halt/shutdown and other encodings never open a bus cycle.
  assign w_start = ce && (!cpu_s1_n || !cpu_s0_n) &&
                   (w_mrd || w_mwr || w_iord || w_iowr || w_inta);

  assign w_io         = !cpu_mio;
  assign w_space_mask = w_io ? AW'(12'hFFF) : '1;

  // Descending scan so the lowest-indexed matching window is the one kept.
  always_comb begin
    w_hit = 1'b0;
    w_ch  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if ((((cpu_a ^ CH_BASE[i*AW +: AW]) & CH_MASK[i*AW +: AW] & w_space_mask) == '0) &&
          (CH_IO[i] == w_io)) begin
        w_hit = 1'b1;
        w_ch  = CW'(i);
      end
    end
  end

  assign w_ack_done = r_is_rd ? (rd_ack[r_ch] == r_rd_req[r_ch])
                              : (wr_ack[r_ch] == r_wr_req[r_ch]);
  assign w_ch_data  = ch_dout[r_ch*DW +: DW];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_c_a         <= '0;
      r_c_d         <= '0;
      r_c_bhe_n     <= 1'b1;
      r_ready       <= 1'b1;
      r_oe          <= 1'b0;
      r_dout        <= '0;
      r_rd_req      <= '0;
      r_wr_req      <= '0;
      r_is_rd       <= 1'b0;
      r_is_wr       <= 1'b0;
      r_is_inta     <= 1'b0;
      r_ch          <= '0;
      r_hit         <= 1'b0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_c_a     <= cpu_a;
            r_is_rd   <= w_mrd || w_iord;
            r_is_wr   <= w_mwr || w_iowr;
            r_is_inta <= w_inta;
            r_ch      <= w_ch;
            r_hit     <= w_hit;
            r_ready   <= 1'b0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (ce) begin
            r_c_d     <= cpu_d_in;
            r_c_bhe_n <= cpu_bhe_n;
            if (r_is_inta) begin
              r_dout  <= {{(DW-8){1'b0}}, irq_vector};
              r_oe    <= 1'b1;
              r_state <= S_DONE;
            end else if (r_hit && (r_is_rd || r_is_wr)) begin
              if (r_is_rd) r_rd_req[r_ch] <= ~r_rd_req[r_ch];
              else         r_wr_req[r_ch] <= ~r_wr_req[r_ch];
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              if (r_is_rd) begin
                r_dout <= '1;
                r_oe   <= 1'b1;
              end
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + TW'(1);
          // Equality rather than edge compare lets a late ack be absorbed silently.
          if (w_ack_done) begin
            if (r_is_rd) begin
              r_dout <= w_ch_data;
              r_oe   <= 1'b1;
            end
            r_state <= S_DONE;
          end else if (r_cnt == TO_LAST) begin
            r_timeout_err <= 1'b1;
            if (r_is_rd) begin
              r_dout <= '1;
              r_oe   <= 1'b1;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (ce) begin
            r_ready <= 1'b1;
            r_oe    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_ready   = r_ready;
  assign cpu_d_out   = r_dout;
  assign cpu_d_oe    = r_oe;
  assign c_a         = r_c_a;
  assign c_d         = r_c_d;
  assign c_bhe_n     = r_c_bhe_n;
  assign rd_req      = r_rd_req;
  assign wr_req      = r_wr_req;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge: read data checked through an expected queue
// filled when each cycle is launched and drained when the bridge drives the bus.
module tb_cpu_bus_bridge;
  localparam int NCH = 8;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam logic [NCH*AW-1:0] CH_BASE = {24'h000FFF, 24'h000FFF, 24'h200000, 24'h000FFF,
                                           24'h200000, 24'h000040, 24'h100000, 24'h0A0000};
  localparam logic [NCH*AW-1:0] CH_MASK = {24'hFFFFFF, 24'hFFFFFF, 24'hFFF000, 24'hFFFFFF,
                                           24'hFF0000, 24'h000FFC, 24'hFF0000, 24'hFE0000};
  localparam logic [NCH-1:0] CH_IO = 8'b1101_0100;

  localparam logic [3:0] C_MRD  = 4'b1101;
  localparam logic [3:0] C_MWR  = 4'b1110;
  localparam logic [3:0] C_IOWR = 4'b1010;
  localparam logic [3:0] C_INTA = 4'b0000;

  logic clk = 1'b0, reset, ce;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_d_in;
  logic cpu_bhe_n, cpu_s0_n, cpu_s1_n, cpu_mio, cpu_inta_n;
  logic cpu_ready, cpu_d_oe, c_bhe_n, timeout_err, busy;
  logic [DW-1:0] cpu_d_out, c_d;
  logic [AW-1:0] c_a;
  logic [NCH-1:0] rd_req, wr_req, rd_ack, wr_ack;
  logic [NCH*DW-1:0] ch_dout;
  logic [7:0] irq_vector;
  logic [1:0] dbg_state;

  cpu_bus_bridge #(.NCH(NCH), .AW(AW), .DW(DW), .CH_BASE(CH_BASE), .CH_MASK(CH_MASK),
                   .CH_IO(CH_IO), .TIMEOUT(16), .TW(8)) dut (
    .clk(clk), .reset(reset), .ce(ce), .cpu_a(cpu_a), .cpu_d_in(cpu_d_in),
    .cpu_bhe_n(cpu_bhe_n), .cpu_s0_n(cpu_s0_n), .cpu_s1_n(cpu_s1_n), .cpu_mio(cpu_mio),
    .cpu_inta_n(cpu_inta_n), .cpu_ready(cpu_ready), .cpu_d_out(cpu_d_out), .cpu_d_oe(cpu_d_oe),
    .c_a(c_a), .c_d(c_d), .c_bhe_n(c_bhe_n), .rd_req(rd_req), .wr_req(wr_req),
    .rd_ack(rd_ack), .wr_ack(wr_ack), .ch_dout(ch_dout), .irq_vector(irq_vector),
    .timeout_err(timeout_err), .busy(busy), .dbg_state(dbg_state));

  // Clock, CPU-phase strobe every fourth clk
  always #5 clk = ~clk;
  initial begin
    ce = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 ce = 1'b1;
      @(posedge clk);
      #1 ce = 1'b0;
    end
  end

  int n_vec = 0, n_fail = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Peripheral model: each enabled channel echoes its request toggle after 3 clk
  logic [NCH-1:0] ack_en = 8'b1111_1101;
  int rd_dly[NCH], wr_dly[NCH];
  initial begin
    rd_ack = '0;
    wr_ack = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        rd_ack = '0;
        wr_ack = '0;
        for (int i = 0; i < NCH; i++) begin rd_dly[i] = 0; wr_dly[i] = 0; end
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (ack_en[i] && rd_req[i] != rd_ack[i]) begin
            rd_dly[i]++;
            if (rd_dly[i] == 3) begin rd_ack[i] = rd_req[i]; rd_dly[i] = 0; end
          end else rd_dly[i] = 0;
          if (ack_en[i] && wr_req[i] != wr_ack[i]) begin
            wr_dly[i]++;
            if (wr_dly[i] == 3) begin wr_ack[i] = wr_req[i]; wr_dly[i] = 0; end
          end else wr_dly[i] = 0;
        end
      end
    end
  end

  // Monitor: cycle count, toggle tallies, timeout pulses, scoreboard drain
  int cyc = 0, tog_total = 0, to_cnt = 0, req_cyc = 0, to_cyc = 0;
  logic [NCH-1:0] prev_rd = '0, prev_wr = '0;
  logic prev_oe = 1'b0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      for (int i = 0; i < NCH; i++) begin
        if (rd_req[i] !== prev_rd[i]) begin tog_total++; req_cyc = cyc; end
        if (wr_req[i] !== prev_wr[i]) tog_total++;
      end
      if (timeout_err === 1'b1) begin to_cnt++; to_cyc = cyc; end
      if (cpu_d_oe === 1'b1 && !prev_oe) begin
        if (exp_q.size() == 0) chk("unexpected_oe", 32'd1, 32'd0);
        else chk("rdata", 32'(cpu_d_out), 32'(exp_q.pop_front()));
      end
    end
    prev_rd = rd_req;
    prev_wr = wr_req;
    prev_oe = (cpu_d_oe === 1'b1);
  end

  task automatic wait_ce();
    do @(posedge clk); while (ce !== 1'b1);
  endtask

  // Present status for one phase, then count phases until READY returns.
  task automatic bus_cycle(input logic [3:0] cmd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic bhe_n,
                           output int n_ce);
    bit done;
    wait_ce();
    #2;
    cpu_a = addr;
    {cpu_inta_n, cpu_mio, cpu_s1_n, cpu_s0_n} = cmd;
    cpu_bhe_n = bhe_n;
    cpu_d_in = wdata;
    wait_ce();
    #2;
    {cpu_inta_n, cpu_s1_n, cpu_s0_n} = 3'b111;
    chk("ready_low", 32'(cpu_ready), 32'd0);
    n_ce = 0;
    done = 0;
    while (!done && n_ce < 40) begin
      wait_ce();
      #2;
      n_ce++;
      if (cpu_ready === 1'b1) done = 1;
    end
    chk("cycle_done", 32'(done), 32'd1);
  endtask

  logic [NCH-1:0] snap_rd, snap_wr;
  int snap_tog, snap_to, n_ce;

  task automatic snap();
    snap_rd = rd_req;
    snap_wr = wr_req;
    snap_tog = tog_total;
    snap_to = to_cnt;
  endtask

  task automatic chk_tog(input string tag, input logic [NCH-1:0] exp_rd,
                         input logic [NCH-1:0] exp_wr);
    chk({tag, "_rd"}, 32'(rd_req ^ snap_rd), 32'(exp_rd));
    chk({tag, "_wr"}, 32'(wr_req ^ snap_wr), 32'(exp_wr));
    chk({tag, "_count"}, 32'(tog_total - snap_tog), 32'($countones({exp_rd, exp_wr})));
  endtask

  initial begin
    reset = 1'b1;
    cpu_a = '0; cpu_d_in = '0; cpu_bhe_n = 1'b1;
    {cpu_inta_n, cpu_mio, cpu_s1_n, cpu_s0_n} = 4'b1111;
    irq_vector = 8'h00;
    ch_dout = '0;
    ch_dout[0*DW +: DW] = 16'hBEEF;
    ch_dout[1*DW +: DW] = 16'h1111;
    ch_dout[2*DW +: DW] = 16'h2222;
    ch_dout[3*DW +: DW] = 16'h3333;
    ch_dout[5*DW +: DW] = 16'h5555;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_oe", 32'(cpu_d_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_bhe_n", 32'(c_bhe_n), 32'd1);
    chk("rst_dout", 32'(cpu_d_out), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    // Memory read, channel 0
    snap();
    exp_q.push_back(16'hBEEF);
    bus_cycle(C_MRD, 24'h0A1234, 16'h0000, 1'b0, n_ce);
    chk_tog("mrd_ch0", 8'h01, 8'h00);
    chk("mrd_ch0_lat", 32'(n_ce >= 2), 32'd1);
    chk("mrd_ch0_c_a", 32'(c_a), 32'h0A1234);
    chk("mrd_ch0_oe_off", 32'(cpu_d_oe), 32'd0);

    // I/O write, channel 2
    snap();
    bus_cycle(C_IOWR, 24'h000043, 16'h0036, 1'b1, n_ce);
    chk_tog("iowr_ch2", 8'h00, 8'h04);
    chk("iowr_c_a", 32'(c_a[11:0]), 32'h043);
    chk("iowr_c_d", 32'(c_d), 32'h0036);
    chk("iowr_bhe_n", 32'(c_bhe_n), 32'd1);

    // Memory write, channel 0, low BHE#
    snap();
    bus_cycle(C_MWR, 24'h0A0010, 16'hA55A, 1'b0, n_ce);
    chk_tog("mwr_ch0", 8'h00, 8'h01);
    chk("mwr_c_d", 32'(c_d), 32'hA55A);
    chk("mwr_bhe_n", 32'(c_bhe_n), 32'd0);

    // Unmapped read: default data, two phases
    snap();
    exp_q.push_back(16'hFFFF);
    bus_cycle(C_MRD, 24'h800000, 16'h0000, 1'b1, n_ce);
    chk_tog("unmapped", 8'h00, 8'h00);
    chk("unmapped_lat", 32'(n_ce), 32'd2);

    // Channel 1 never acknowledges: forced termination
    snap();
    exp_q.push_back(16'hFFFF);
    bus_cycle(C_MRD, 24'h100010, 16'h0000, 1'b1, n_ce);
    chk_tog("timeout", 8'h02, 8'h00);
    chk("timeout_pulses", 32'(to_cnt - snap_to), 32'd1);
    chk("timeout_clk", 32'(to_cyc - req_cyc), 32'd16);

    // Late ack on channel 1, then a normal read must be unaffected
    ack_en[1] = 1'b1;
    repeat (8) @(posedge clk);
    ack_en[1] = 1'b0;
    snap();
    exp_q.push_back(16'hBEEF);
    bus_cycle(C_MRD, 24'h0BFFFE, 16'h0000, 1'b1, n_ce);
    chk_tog("after_late_ack", 8'h01, 8'h00);
    chk("after_late_ack_to", 32'(to_cnt - snap_to), 32'd0);

    // Overlapping windows: lowest index wins
    snap();
    exp_q.push_back(16'h3333);
    bus_cycle(C_MRD, 24'h200100, 16'h0000, 1'b1, n_ce);
    chk_tog("overlap", 8'h08, 8'h00);

    // Interrupt acknowledge
    irq_vector = 8'h08;
    snap();
    exp_q.push_back(16'h0008);
    bus_cycle(C_INTA, 24'h000000, 16'h0000, 1'b1, n_ce);
    chk_tog("inta", 8'h00, 8'h00);

    // Reset while waiting on channel 1
    wait_ce();
    #2;
    cpu_a = 24'h100020;
    {cpu_inta_n, cpu_mio, cpu_s1_n, cpu_s0_n} = C_MRD;
    wait_ce();
    #2;
    {cpu_inta_n, cpu_s1_n, cpu_s0_n} = 3'b111;
    wait_ce();
    repeat (2) @(posedge clk);
    #2;
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_rd_req_set", 32'(rd_req != 8'h00), 32'd1);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_rd_req", 32'(rd_req), 32'd0);
    chk("midrst_wr_req", 32'(wr_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cpu_ready), 32'd1);
    chk("midrst_oe", 32'(cpu_d_oe), 32'd0);

    repeat (4) @(posedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
